dcom_buffer_arbiter: RTL and testbench

DCOM_BUFFER_ARBITER -- requirements
Module: dcom_buffer_arbiter

---
 rtl/dcom_buffer_arbiter_pkg.sv | 15 +
 rtl/dcom_buffer_arbiter_rr_priority_pick.sv | 33 +++
 rtl/dcom_buffer_arbiter.sv | 116 +++++++++++
 tb/tb_dcom_buffer_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcom_buffer_arbiter_pkg.sv
// Shared types and default sizing for the DCOM buffer arbiter.
package dcom_buffer_arbiter_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam int N_CH_D      = 8;
    localparam int ADDR_W_D    = 12;
    localparam int DATA_W_D    = 64;
    localparam int MAX_BEATS_D = 16;
    localparam int IDX_W       = 3;

endpackage

// File: rtl/dcom_buffer_arbiter_rr_priority_pick.sv
// Round-robin picker: first requester strictly after last_ptr, wrapping.
module rr_priority_pick #(
    parameter int N_CH = 8,
    parameter int IW   = 3
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   last_ptr,
    output logic            valid,
    output logic [IW-1:0]   index,
    output logic [N_CH-1:0] onehot
);

    always_comb begin
        int c;
        logic [IW-1:0] ci;
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        c      = 0;
        ci     = '0;
        for (int i = 1; i <= N_CH; i++) begin
            c = int'(last_ptr) + i;
            if (c >= N_CH) c = c - N_CH;
            ci = IW'(c);
            if (!valid && req[ci]) begin
                valid = 1'b1;
                index = ci;
            end
        end
        if (valid) onehot[index] = 1'b1;
    end

endmodule

// File: rtl/dcom_buffer_arbiter.sv
// Round-robin arbiter muxing N write channels onto one Avalon master.
module dcom_buffer_arbiter
    import dcom_buffer_arbiter_pkg::*;
#(
    parameter int N_CH      = N_CH_D,
    parameter int ADDR_W    = ADDR_W_D,
    parameter int DATA_W    = DATA_W_D,
    parameter int MAX_BEATS = MAX_BEATS_D
) (
    input  logic                       clk50_clk,
    input  logic                       rst_reset_n,
    input  logic [N_CH-1:0]            req_write_i,
    input  logic [N_CH*ADDR_W-1:0]     req_address_i,
    input  logic [N_CH*DATA_W-1:0]     req_writedata_i,
    input  logic [N_CH*DATA_W/8-1:0]   req_byteenable_i,
    input  logic [N_CH-1:0]            req_last_i,
    output logic [N_CH-1:0]            req_waitrequest_o,
    output logic [N_CH-1:0]            grant_o,
    output logic [ADDR_W+2:0]          avm_address_o,
    output logic                       avm_write_o,
    output logic [DATA_W-1:0]          avm_writedata_o,
    output logic [DATA_W/8-1:0]        avm_byteenable_o,
    input  logic                       avm_waitrequest_i,
    output logic                       busy_o
);

    localparam int BEW = DATA_W / 8;
    localparam int CW  = $clog2(MAX_BEATS) + 1;

    state_t            state;
    logic [IDX_W-1:0]  cur_idx;
    logic [IDX_W-1:0]  last_ptr;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_CH-1:0]   pick_onehot;
    logic              pick_valid;
    logic [CW-1:0]     beats;
    logic              granted;
    logic              accept;
    logic              cur_write;
    logic              cur_last;
    logic              done;

    rr_priority_pick #(
        .N_CH (N_CH),
        .IW   (IDX_W)
    ) u_pick (
        .req      (req_write_i),
        .last_ptr (last_ptr),
        .valid    (pick_valid),
        .index    (pick_idx),
        .onehot   (pick_onehot)
    );

    assign granted   = (state == GRANT);
    assign busy_o    = granted;
    assign cur_write = req_write_i[cur_idx];
    assign cur_last  = req_last_i[cur_idx];
    assign accept    = avm_write_o && !avm_waitrequest_i;
    // A requester dropping write mid-grant also ends the grant
    assign done = !cur_write ||
                  (accept && (cur_last || beats == CW'(MAX_BEATS - 1)));

    assign req_waitrequest_o = (granted && !avm_waitrequest_i) ?
                               ~grant_o : '1;

    always_comb begin
        avm_write_o      = 1'b0;
        avm_address_o    = '0;
        avm_writedata_o  = '0;
        avm_byteenable_o = '0;
        if (granted) begin
            avm_write_o      = cur_write;
            avm_address_o    = {cur_idx,
                req_address_i[int'(cur_idx)*ADDR_W +: ADDR_W]};
            avm_writedata_o  =
                req_writedata_i[int'(cur_idx)*DATA_W +: DATA_W];
            avm_byteenable_o =
                req_byteenable_i[int'(cur_idx)*BEW +: BEW];
        end
    end

    always_ff @(posedge clk50_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            state    <= IDLE;
            grant_o  <= '0;
            cur_idx  <= '0;
            beats    <= '0;
            last_ptr <= IDX_W'(N_CH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= GRANT;
                        grant_o <= pick_onehot;
                        cur_idx <= pick_idx;
                        beats   <= '0;
                    end else begin
                        grant_o <= '0;
                    end
                end
                GRANT: begin
                    if (done) begin
                        state    <= IDLE;
                        grant_o  <= '0;
                        beats    <= '0;
                        last_ptr <= cur_idx;
                    end else if (accept) begin
                        beats <= beats + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcom_buffer_arbiter.sv
// Directed self-checking bench for dcom_buffer_arbiter.
module tb_dcom_buffer_arbiter;

    localparam int N  = 8;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int BW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      wr = '0;
    logic [N-1:0]      last = '0;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N*BW-1:0]   be;
    logic [N-1:0]      waitreq;
    logic [N-1:0]      grant;
    logic [AW+2:0]     avm_addr;
    logic              avm_wr;
    logic [DW-1:0]     avm_data;
    logic [BW-1:0]     avm_be;
    logic              avm_wait = 1'b0;
    logic              busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dcom_buffer_arbiter dut (
        .clk50_clk         (clk),
        .rst_reset_n       (rst_n),
        .req_write_i       (wr),
        .req_address_i     (addr),
        .req_writedata_i   (wdata),
        .req_byteenable_i  (be),
        .req_last_i        (last),
        .req_waitrequest_o (waitreq),
        .grant_o           (grant),
        .avm_address_o     (avm_addr),
        .avm_write_o       (avm_wr),
        .avm_writedata_o   (avm_data),
        .avm_byteenable_o  (avm_be),
        .avm_waitrequest_i (avm_wait),
        .busy_o            (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        tick();
        total++;
        if (grant !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_state grant=%h busy=%b exp 00/0",
                     grant, busy);
        end
        total++;
        if (waitreq !== 8'hFF || avm_wr !== 1'b0 || avm_addr !== '0) begin
            bad++;
            $display("FAIL rst_outs wreq=%h wr=%b addr=%h exp ff/0/0",
                     waitreq, avm_wr, avm_addr);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle busy=%b exp 0", busy);
        end
    endtask

    task automatic test_single;
        int acc;
        acc = 0;
        wr = 8'h04;
        #1;
        total++;
        if (grant !== 8'h00) begin
            bad++;
            $display("FAIL s1_latency grant=%h exp 00", grant);
        end
        tick();
        total++;
        if (grant !== 8'h04 || busy !== 1'b1) begin
            bad++;
            $display("FAIL s1_grant grant=%h busy=%b exp 04/1",
                     grant, busy);
        end
        total++;
        if (avm_addr !== 15'h2102 || waitreq !== 8'hFB) begin
            bad++;
            $display("FAIL s1_addr addr=%h wreq=%h exp 2102/fb",
                     avm_addr, waitreq);
        end
        total++;
        if (avm_data !== 64'hA2A2A2A2A2A2A2A2 || avm_be !== 8'hF2) begin
            bad++;
            $display("FAIL s1_data data=%h be=%h exp a2../f2",
                     avm_data, avm_be);
        end
        for (int b = 1; b <= 3; b++) begin
            last[2] = (b == 3);
            #1;
            if (avm_wr && !avm_wait) acc++;
            tick();
        end
        wr = '0;
        last = '0;
        #1;
        total++;
        if (acc !== 3 || busy !== 1'b0 || grant !== 8'h00) begin
            bad++;
            $display("FAIL s1_beats acc=%0d busy=%b grant=%h exp 3/0/00",
                     acc, busy, grant);
        end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp;
        apply_reset();
        wr = 8'hFF;
        last = 8'hFF;
        for (int i = 0; i <= 8; i++) begin
            exp = 8'b1 << (i % 8);
            tick();
            total++;
            if (grant !== exp) begin
                bad++;
                $display("FAIL rr_grant%0d grant=%h exp %h", i, grant, exp);
            end
            if (i == 8) wr = '0;
            tick();
            total++;
            if (grant !== 8'h00 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rr_gap%0d grant=%h busy=%b exp 00/0",
                         i, grant, busy);
            end
        end
        last = '0;
    endtask

    task automatic test_max_beats;
        int acc;
        acc = 0;
        last = '0;
        wr = 8'h20;
        tick();
        total++;
        if (grant !== 8'h20) begin
            bad++;
            $display("FAIL max_grant grant=%h exp 20", grant);
        end
        wr = 8'h62;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            if (avm_wr && !avm_wait) acc++;
            tick();
        end
        total++;
        if (acc !== 16 || grant !== 8'h00) begin
            bad++;
            $display("FAIL max_beats acc=%0d grant=%h exp 16/00",
                     acc, grant);
        end
        tick();
        total++;
        if (grant !== 8'h40) begin
            bad++;
            $display("FAIL max_next grant=%h exp 40", grant);
        end
        wr = '0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL max_drop busy=%b exp 0", busy);
        end
    endtask

    task automatic test_stall;
        int acc;
        int stall;
        logic ok;
        logic [DW-1:0] exp;
        acc = 0;
        stall = 0;
        ok = 1'b1;
        exp = wdata[3*DW +: DW];
        wr = 8'h08;
        tick();
        total++;
        if (grant !== 8'h08) begin
            bad++;
            $display("FAIL st_grant grant=%h exp 08", grant);
        end
        for (int c = 0; c < 60; c++) begin
            if (!busy) break;
            if (acc == 14 && stall < 4) begin
                avm_wait = 1'b1;
                stall++;
                #1;
                if (waitreq[3] !== 1'b1 || avm_data !== exp ||
                    avm_wr !== 1'b1 || busy !== 1'b1) ok = 1'b0;
            end else begin
                avm_wait = 1'b0;
                #1;
            end
            if (avm_wr && !avm_wait) acc++;
            tick();
        end
        avm_wait = 1'b0;
        wr = '0;
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL st_hold ok=%b exp 1", ok);
        end
        total++;
        if (acc !== 16 || busy !== 1'b0) begin
            bad++;
            $display("FAIL st_beats acc=%0d busy=%b exp 16/0", acc, busy);
        end
    endtask

    task automatic test_drop;
        int acc;
        acc = 0;
        wr = 8'h02;
        tick();
        total++;
        if (grant !== 8'h02) begin
            bad++;
            $display("FAIL dr_grant grant=%h exp 02", grant);
        end
        tick();
        tick();
        wr = '0;
        #1;
        total++;
        if (avm_wr !== 1'b0) begin
            bad++;
            $display("FAIL dr_mux wr=%b exp 0", avm_wr);
        end
        tick();
        total++;
        if (busy !== 1'b0 || grant !== 8'h00) begin
            bad++;
            $display("FAIL dr_release busy=%b grant=%h exp 0/00",
                     busy, grant);
        end
        wr = 8'h06;
        tick();
        total++;
        if (grant !== 8'h04) begin
            bad++;
            $display("FAIL dr_lastptr grant=%h exp 04", grant);
        end
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            if (avm_wr && !avm_wait) acc++;
            tick();
        end
        wr = '0;
        total++;
        if (acc !== 16) begin
            bad++;
            $display("FAIL dr_cnt_clear acc=%0d exp 16", acc);
        end
    endtask

    task automatic test_reset_mid;
        wr = 8'h11;
        tick();
        total++;
        if (grant !== 8'h10) begin
            bad++;
            $display("FAIL rm_grant grant=%h exp 10", grant);
        end
        for (int b = 0; b < 4; b++) tick();
        total++;
        if (avm_wr !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rm_beat5 wr=%b busy=%b exp 1/1", avm_wr, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (grant !== 8'h00 || busy !== 1'b0 || avm_wr !== 1'b0 ||
            waitreq !== 8'hFF) begin
            bad++;
            $display("FAIL rm_async grant=%h busy=%b wr=%b wreq=%h",
                     grant, busy, avm_wr, waitreq);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (avm_wr !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rm_post wr=%b busy=%b exp 0/0", avm_wr, busy);
        end
        tick();
        total++;
        if (grant !== 8'h01) begin
            bad++;
            $display("FAIL rm_first grant=%h exp 01", grant);
        end
        wr = '0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rm_end busy=%b exp 0", busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            addr[k*AW +: AW]  = AW'(12'h100 + k);
            wdata[k*DW +: DW] = {8{8'(8'hA0 + k)}};
            be[k*BW +: BW]    = 8'(8'hF0 + k);
        end
        test_reset();
        test_single();
        test_round_robin();
        test_max_beats();
        test_stall();
        test_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
